cross_bar_order_fifo: RTL and testbench
=======================================

Name: cross_bar_order_fifo

Overview:
- Parametrised per-slave ordering FIFO for the crossbar.
- Records, in grant order, the master index that owns each outstanding slave transaction. Returns them in the same order so the response path can be steered back to the correct master.
- Generalises the fixed SLAVE_N-deep ordering queue with configurable width and depth, plus full/almost-full/count status, synchronous flush and protected pointers.

Parameters:
- ID_W, 2, width of stored master index (bits).
- DEPTH, 4, number of entries; any integer >= 2, not restricted to a power of two.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of all entries.
- wr  in  1  push request.
- wdata  in  ID_W  master index to push.
- rd  in  1  pop request.
- rdata  out  ID_W  head entry (show-ahead); valid when empty=0.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (areset=1, asynchronous): pointers=0, count=0, storage=0.
  - Outputs during reset: empty=1, full=0, almost_full=0 (or 1 only if AF_LEVEL=0, which is illegal), rdata=0.
- Pointers: rd_pt and wr_pt each range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. Wrap is not implied by width.
- Full/empty: derived from the count register, never from pointer equality. A full FIFO must not read as empty.
- Push: accepted iff wr=1 and full=0.
  - Storage[wr_pt] <= wdata; wr_pt advances.
  - A push while full is dropped: storage, pointers and count are unchanged.
- Pop: accepted iff rd=1 and empty=0; rd_pt advances. A pop while empty is ignored.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Push and pop in the same cycle:
  - when full: pop is accepted, push is rejected (no pass-through), so count goes DEPTH -> DEPTH-1.
  - when empty: push is accepted, pop is ignored, so count goes 0 -> 1.
- rdata = storage[rd_pt], combinational. Zero-latency show-ahead: the entry written in cycle N is visible on rdata in cycle N+1 if the FIFO was empty.
- count, full, empty, almost_full are registered-state derived and update on the edge after the accepted operation.
- flush=1: at the next edge, pointers=0 and count=0. Flush overrides wr and rd in the same cycle; storage contents need not be cleared.
- Reset asserted mid-operation: immediate return to the reset state. No partial operation survives.

Optional Feature:
- Macro CROSS_BAR_ORDER_FIFO_ERR_EN.
- When defined, adds two outputs: ovf (wr=1 while full=1) and udf (rd=1 while empty=1).
  - Both are sticky; cleared only by areset or flush.
  - Each sets on the edge after the offending request.
- When undefined, the ports and their logic are absent; illegal requests are silently ignored as above.

Test Plan:
- Reset/basic (DEPTH=4, ID_W=2): after areset -> empty=1, full=0, count=0. Push 3 -> count=1, rdata=3, empty=0 next cycle.
- Order/wrap: push 1,2,3,0, pop 2, push 2,1, pop 4 -> rdata sequence 1,2,3,0,2,1. Pointers wrap 3->0 with no loss; ends empty=1.
- Full boundary: push 4 entries -> full=1, almost_full=1, count=4. Push 5th value 2 -> dropped; subsequent pops return the original 4 values. With ERR_EN, ovf=1.
- Simultaneous push and pop:
  - at count=2 -> count stays 2 and order is preserved.
  - at full -> count=3.
  - at empty -> count=1, rdata=wdata.
- Flush/underflow: at count=3, assert flush with wr=1 -> count=0, empty=1. Then rd=1 -> no change; with ERR_EN, udf=1 until next flush.
- Non-power-of-two (DEPTH=5, AF_LEVEL=3): almost_full rises at count 3. Ten push/pop cycles wrap rd_pt/wr_pt 4->0 correctly with data intact.

Source files
------------

// File: rtl/cross_bar_order_fifo.sv
// Per-slave ordering FIFO: holds the granted master index of each outstanding slave transaction, in grant order.
// Define CROSS_BAR_ORDER_FIFO_ERR_EN to add sticky ovf/udf error outputs.
module cross_bar_order_fifo #(
  parameter int ID_W     = 2,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             flush,
  input  logic             wr,
  input  logic [ID_W-1:0]  wdata,
  input  logic             rd,
  output logic [ID_W-1:0]  rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CNT_W-1:0] count
`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
  ,
  output logic             ovf,
  output logic             udf
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_pt;
  logic [PTR_W-1:0] wr_pt;
  logic             push_ok;
  logic             pop_ok;

  // Status comes only from the count, so a full FIFO can never alias to empty.
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);
  assign push_ok     = wr && !full && !flush;
  assign pop_ok      = rd && !empty && !flush;
  assign rdata       = mem[rd_pt];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_pt] <= wdata;
    end
  end

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_pt <= '0;
      rd_pt <= '0;
    end else if (flush) begin
      wr_pt <= '0;
      rd_pt <= '0;
    end else begin
      if (push_ok) begin
        wr_pt <= (wr_pt == LAST_PT) ? '0 : wr_pt + 1'b1;
      end
      if (pop_ok) begin
        rd_pt <= (rd_pt == LAST_PT) ? '0 : rd_pt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr && full) begin
        ovf <= 1'b1;
      end
      if (rd && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cross_bar_order_fifo.sv
// Directed, table-driven bench for cross_bar_order_fifo (DEPTH=4 and DEPTH=5 instances).
// Error-flag checks are compiled in when CROSS_BAR_ORDER_FIFO_ERR_EN is defined.
module tb_cross_bar_order_fifo;

  typedef struct {
    logic       flush;
    logic       wr;
    logic [1:0] wdata;
    logic       rd;
    logic [1:0] rdata;
    logic       chk_rd;
    logic       empty;
    logic       full;
    logic       af;
    logic [2:0] count;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic clk = 1'b0;
  logic areset = 1'b1;

  logic       flush4 = 1'b0, wr4 = 1'b0, rd4 = 1'b0;
  logic [1:0] wdata4 = '0;
  logic [1:0] rdata4;
  logic       empty4, full4, af4;
  logic [2:0] count4;

  logic       flush5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
  logic [2:0] wdata5 = '0;
  logic [2:0] rdata5;
  logic       empty5, full5, af5;
  logic [2:0] count5;

`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
  logic ovf4, udf4, ovf5, udf5;
`endif

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];
  logic [2:0] model[$];

  always #5 clk = ~clk;

  cross_bar_order_fifo #(.ID_W(2), .DEPTH(4)) u4 (
    .clk(clk), .areset(areset), .flush(flush4), .wr(wr4), .wdata(wdata4), .rd(rd4),
    .rdata(rdata4), .empty(empty4), .full(full4), .almost_full(af4), .count(count4)
`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
    , .ovf(ovf4), .udf(udf4)
`endif
  );

  cross_bar_order_fifo #(.ID_W(3), .DEPTH(5), .AF_LEVEL(3)) u5 (
    .clk(clk), .areset(areset), .flush(flush5), .wr(wr5), .wdata(wdata5), .rd(rd5),
    .rdata(rdata5), .empty(empty5), .full(full5), .almost_full(af5), .count(count5)
`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
    , .ovf(ovf5), .udf(udf5)
`endif
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven on the falling edge and outputs sampled on the next falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    flush4 = v.flush; wr4 = v.wr; wdata4 = v.wdata; rd4 = v.rd;
    @(posedge clk);
    @(negedge clk);
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, " count"}, int'(count4), int'(v.count));
    checkOutput({tag, " empty"}, int'(empty4), int'(v.empty));
    checkOutput({tag, " full"}, int'(full4), int'(v.full));
    checkOutput({tag, " almost_full"}, int'(af4), int'(v.af));
    if (v.chk_rd) checkOutput({tag, " rdata"}, int'(rdata4), int'(v.rdata));
`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
    checkOutput({tag, " ovf"}, int'(ovf4), int'(v.ovf));
    checkOutput({tag, " udf"}, int'(udf4), int'(v.udf));
`endif
  endtask

  task automatic step5(input logic w, input logic [2:0] d, input logic r);
    wr5 = w; wdata5 = d; rd5 = r;
    @(posedge clk);
    @(negedge clk);
    wr5 = 1'b0; rd5 = 1'b0;
  endtask

  initial begin
    // flush wr wd rd | rdata chk empty full af count ovf udf
    // Basic push/pop
    vecs.push_back(vec_t'{0,1,2'd3,0, 2'd3,1, 0,0,0,3'd1, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,0, 1,0,0,3'd0, 0,0});
    // Order and pointer wrap
    vecs.push_back(vec_t'{0,1,2'd1,0, 2'd1,1, 0,0,0,3'd1, 0,0});
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd1,1, 0,0,0,3'd2, 0,0});
    vecs.push_back(vec_t'{0,1,2'd3,0, 2'd1,1, 0,0,1,3'd3, 0,0});
    vecs.push_back(vec_t'{0,1,2'd0,0, 2'd1,1, 0,1,1,3'd4, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd2,1, 0,0,1,3'd3, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd3,1, 0,0,0,3'd2, 0,0});
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd3,1, 0,0,1,3'd3, 0,0});
    vecs.push_back(vec_t'{0,1,2'd1,0, 2'd3,1, 0,1,1,3'd4, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,1, 0,0,1,3'd3, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd2,1, 0,0,0,3'd2, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd1,1, 0,0,0,3'd1, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,0, 1,0,0,3'd0, 0,0});
    // Full boundary, dropped push, simultaneous ops at full / mid / empty
    vecs.push_back(vec_t'{0,1,2'd1,0, 2'd1,1, 0,0,0,3'd1, 0,0});
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd1,1, 0,0,0,3'd2, 0,0});
    vecs.push_back(vec_t'{0,1,2'd3,0, 2'd1,1, 0,0,1,3'd3, 0,0});
    vecs.push_back(vec_t'{0,1,2'd0,0, 2'd1,1, 0,1,1,3'd4, 0,0});
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd1,1, 0,1,1,3'd4, 1,0});
    vecs.push_back(vec_t'{0,1,2'd3,1, 2'd2,1, 0,0,1,3'd3, 1,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd3,1, 0,0,0,3'd2, 1,0});
    vecs.push_back(vec_t'{0,1,2'd2,1, 2'd0,1, 0,0,0,3'd2, 1,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd2,1, 0,0,0,3'd1, 1,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,0, 1,0,0,3'd0, 1,0});
    vecs.push_back(vec_t'{0,1,2'd1,1, 2'd1,1, 0,0,0,3'd1, 1,1});
    // Flush overriding a push, then underflow
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd1,1, 0,0,0,3'd2, 1,1});
    vecs.push_back(vec_t'{0,1,2'd3,0, 2'd1,1, 0,0,1,3'd3, 1,1});
    vecs.push_back(vec_t'{1,1,2'd0,0, 2'd0,0, 1,0,0,3'd0, 0,0});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,0, 1,0,0,3'd0, 0,1});
    vecs.push_back(vec_t'{0,1,2'd2,0, 2'd2,1, 0,0,0,3'd1, 0,1});
    vecs.push_back(vec_t'{0,0,2'd0,1, 2'd0,0, 1,0,0,3'd0, 0,1});

    // Check the reset state while reset is still held.
    #12;
    checkOutput("reset count", int'(count4), 0);
    checkOutput("reset empty", int'(empty4), 1);
    checkOutput("reset full", int'(full4), 0);
    checkOutput("reset almost_full", int'(af4), 0);
    checkOutput("reset rdata", int'(rdata4), 0);
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end
    flush4 = 1'b0; wr4 = 1'b0; rd4 = 1'b0;

    // Asynchronous reset in the middle of operation clears without a clock edge.
    wr4 = 1'b1; wdata4 = 2'd3;
    @(posedge clk); @(negedge clk);
    wdata4 = 2'd1;
    @(posedge clk); @(negedge clk);
    wr4 = 1'b0;
    checkOutput("pre-reset count", int'(count4), 2);
    #2 areset = 1'b1;
    #1;
    checkOutput("midreset count", int'(count4), 0);
    checkOutput("midreset empty", int'(empty4), 1);
    checkOutput("midreset rdata", int'(rdata4), 0);
`ifdef CROSS_BAR_ORDER_FIFO_ERR_EN
    checkOutput("midreset udf", int'(udf4), 0);
`endif
    @(negedge clk);
    areset = 1'b0;

    // DEPTH=5, AF_LEVEL=3: almost_full threshold, then ten cycles of push+pop to wrap pointers.
    step5(1'b1, 3'd1, 1'b0); model.push_back(3'd1);
    step5(1'b1, 3'd2, 1'b0); model.push_back(3'd2);
    checkOutput("d5 count2", int'(count5), 2);
    checkOutput("d5 af at 2", int'(af5), 0);
    step5(1'b1, 3'd3, 1'b0); model.push_back(3'd3);
    checkOutput("d5 af at 3", int'(af5), 1);
    for (int i = 0; i < 10; i++) begin
      logic [2:0] d;
      d = 3'((i + 4) % 8);
      checkOutput($sformatf("d5 head%0d", i), int'(rdata5), int'(model[0]));
      step5(1'b1, d, 1'b1);
      void'(model.pop_front());
      model.push_back(d);
      checkOutput($sformatf("d5 count%0d", i), int'(count5), 3);
    end
    step5(1'b1, 3'd7, 1'b0); model.push_back(3'd7);
    step5(1'b1, 3'd6, 1'b0); model.push_back(3'd6);
    checkOutput("d5 full", int'(full5), 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("d5 drain%0d", i), int'(rdata5), int'(model[0]));
      step5(1'b0, 3'd0, 1'b1);
      void'(model.pop_front());
    end
    checkOutput("d5 empty", int'(empty5), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
